pool_str_rd: RTL and testbench
==============================

// Module: pool_str_rd
// PURPOSE
//  Read-side initiator for the memory pool: given a start word address and a byte count,
//  issues R4 reads to the pool and streams the packed string back out one byte per handshake.
//  Bytes are unpacked little-endian, so byte 0 is vo[7:0]. Feeds the tokenizer / word-compare
//  path with dictionary names that were stored by W4 writes.
// PARAMETERS
//  ASZ     16  pool word-address width (64K words)
//  DSZ     32  pool data width; fixed at 4 bytes per word
//  LSZ      8  byte-count width (max string 255 bytes)
//  RD_LAT   1  pool read latency, in cycles from op=R4 to vo valid (1..4)
// PORTS
//  clk   in   1        clock, rising-edge
//  rst   in   1        reset, asynchronous, active-low
//  req   in   1        start pulse; sampled only in IDLE
//  sa    in   ASZ      start word address, captured on accepted req
//  len   in   LSZ      byte count, captured on accepted req
//  busy  out  1        high from the cycle after an accepted req until DONE
//  done  out  1        one-cycle completion pulse
//  ob    out  8        output byte
//  ov    out  1        ob valid
//  ordy  in   1        downstream ready; a byte transfers when ov&&ordy
//  op    out  3        pool opcode: NOP, or R4 (pool opcode encoding)
//  ai    out  ASZ      pool word address
//  vo    in   DSZ      pool read data
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; op=NOP, ai=0, ob=0, ov=0, busy=0, done=0; counters cleared.
//  FSM: IDLE -> FETCH -> WAIT -> EMIT -> (FETCH | DONE) -> IDLE.
//   IDLE : req=1 captures sa into addr and len into rem. rem==0 -> DONE; otherwise -> FETCH.
//   FETCH: exactly one cycle with op=R4 and ai=addr; addr<=addr+1 (mod 2^ASZ; wraps 0xFFFF->0).
//   WAIT : op=NOP for RD_LAT cycles. vo is registered into wbuf at the edge ending the RD_LAT-th
//          cycle after FETCH. Byte index bi<=0.
//   EMIT : ov=1, ob=wbuf[8*bi+:8]. On ov&&ordy: rem<=rem-1, bi<=bi+1.
//          Last byte (rem==1) transfers -> DONE. bi==3 transfers with rem>1 -> FETCH.
//          ov&&!ordy: ob, ov and all state are held.
//   DONE : done=1 for one cycle; busy=0, ov=0; -> IDLE.
//  Latency (RD_LAT=1): req at cycle t; op=R4 at t+1; vo valid at t+2; ov=1 from t+3.
//  Word-to-word gap: 1+RD_LAT bubble cycles with ov=0 between byte 3 and the next byte 0.
//   No prefetch; exactly ceil(len/4) R4 ops are issued per request.
//  Partial last word: only rem bytes are emitted; the upper bytes of wbuf are never presented.
//  req while busy: ignored, with no effect on sa/len capture.
//  len==0: done pulses at t+1, no R4 is issued, and ov never rises.
//  op is NOP in every state except FETCH; ai holds its last value when op=NOP.
//  Pool ok/st outputs are not used. The pool read path is taken as always ready.
// TESTING
//  T1 pool preloaded by W4 with "abcdefghijklmnop" at words 0..3; sa=0, len=16, ordy=1 ->
//     ob=0x61..0x70 in order; R4 at ai=0,1,2,3; done 1 cycle after 'p'.
//  T2 sa=1, len=6 -> ob="efghij" (0x65..0x6A); exactly 2 R4 ops (ai=1,2); no third read.
//  T3 len=0 -> done at t+1; op stays NOP; ov stays 0; busy never rises.
//  T4 T1 with ordy alternating 1/0 -> same 16-byte sequence; ob/ov stable in stall cycles.
//  T5 sa=0xFFFF, len=8 -> R4 at ai=0xFFFF then 0x0000; bytes match those two words.
//  T6 rst=0 asserted mid-EMIT of T1 -> op=NOP, ov=0, busy=0 immediately; a new req after
//     release restarts cleanly. A req pulsed while busy in T1 leaves the output unchanged.

Source files
------------

// File: rtl/pool_str_rd.sv
// Purpose: pool read initiator; fetches ceil(len/4) words with R4 and streams the bytes out little-endian.
// Latency: req at t -> R4 at t+1 -> first byte offered at t+2+RD_LAT; 1+RD_LAT bubbles between words.
// Backpressure: ov && !ordy freezes ob, ov and all state; no prefetch, so the pool is never read ahead.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   req    start pulse, only looked at while idle
//   sa     start word address, captured with an accepted req
//   len    byte count, captured with an accepted req (0 completes immediately)
//   busy   high from the cycle after an accepted req until the done cycle
//   done   one-cycle completion pulse
//   ob/ov  output byte and its valid; ordy is the downstream ready
//   op/ai  pool opcode (NOP or R4) and pool word address
//   vo     pool read data, valid RD_LAT cycles after the R4 cycle

module pool_str_rd #(
    parameter int          ASZ    = 16,
    parameter int          DSZ    = 32,
    parameter int          LSZ    = 8,
    parameter int          RD_LAT = 1,
    parameter logic [2:0]  OP_NOP = 3'd0,
    parameter logic [2:0]  OP_R4  = 3'd2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic [ASZ-1:0]  sa,
    input  logic [LSZ-1:0]  len,
    output logic            busy,
    output logic            done,
    output logic [7:0]      ob,
    output logic            ov,
    input  logic            ordy,
    output logic [2:0]      op,
    output logic [ASZ-1:0]  ai,
    input  logic [DSZ-1:0]  vo
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Last WAIT cycle index: the read data is sampled at the edge that ends it.
    localparam logic [1:0] WLAST = 2'(RD_LAT - 1);

    state_t          r_state;
    state_t          w_next;

    logic [ASZ-1:0]  r_addr;   // next word to fetch
    logic [ASZ-1:0]  r_ai;     // address presented to the pool, held while op=NOP
    logic [LSZ-1:0]  r_rem;    // bytes still to be transferred
    logic [1:0]      r_bi;     // byte index inside r_wbuf
    logic [1:0]      r_wcnt;   // cycles spent in WAIT
    logic [DSZ-1:0]  r_wbuf;   // captured pool word

    logic            w_xfer;
    logic            w_last_byte;
    logic            w_word_end;
    logic            w_wait_end;
    logic [7:0]      w_byte;

    assign w_xfer      = (r_state == S_EMIT) && ordy;
    assign w_last_byte = (r_rem == LSZ'(1));
    assign w_word_end  = (r_bi == 2'd3);
    assign w_wait_end  = (r_wcnt == WLAST);

    // Little-endian byte select: byte 0 of the string sits in the low lane.
    always_comb begin
        w_byte = r_wbuf[7:0];
        case (r_bi)
            2'd0:    w_byte = r_wbuf[7:0];
            2'd1:    w_byte = r_wbuf[15:8];
            2'd2:    w_byte = r_wbuf[23:16];
            default: w_byte = r_wbuf[31:24];
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        ov     = 1'b0;
        op     = OP_NOP;
        ai     = r_ai;
        ob     = w_byte;

        case (r_state)
            S_IDLE: begin
                if (req) begin
                    // A zero-length request goes straight to DONE without any read.
                    w_next = (len == '0) ? S_DONE : S_FETCH;
                end
            end

            S_FETCH: begin
                busy   = 1'b1;
                op     = OP_R4;
                w_next = S_WAIT;
            end

            S_WAIT: begin
                busy = 1'b1;
                if (w_wait_end) begin
                    w_next = S_EMIT;
                end
            end

            S_EMIT: begin
                busy = 1'b1;
                ov   = 1'b1;
                if (w_xfer) begin
                    // The length check wins over the word boundary so a string
                    // ending exactly on byte 3 does not trigger an extra read.
                    if (w_last_byte) begin
                        w_next = S_DONE;
                    end else if (w_word_end) begin
                        w_next = S_FETCH;
                    end
                end
            end

            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address, remaining count, byte index, read buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
            r_ai   <= '0;
            r_rem  <= '0;
            r_bi   <= '0;
            r_wcnt <= '0;
            r_wbuf <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_addr <= sa;
                        r_rem  <= len;
                        // ai only moves when a read will actually follow.
                        if (len != '0) begin
                            r_ai <= sa;
                        end
                    end
                end

                S_FETCH: begin
                    // Wraps naturally at the top of the pool.
                    r_addr <= r_addr + ASZ'(1);
                    r_wcnt <= '0;
                end

                S_WAIT: begin
                    if (w_wait_end) begin
                        r_wbuf <= vo;
                        r_bi   <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + 2'd1;
                    end
                end

                S_EMIT: begin
                    if (w_xfer) begin
                        r_rem <= r_rem - LSZ'(1);
                        r_bi  <= r_bi + 2'd1;
                        // Preload the pool address for the upcoming FETCH;
                        // r_addr already points at the next word.
                        if (w_word_end && !w_last_byte) begin
                            r_ai <= r_addr;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_str_rd.sv
module tb_pool_str_rd;

    localparam int         ASZ    = 16;
    localparam int         DSZ    = 32;
    localparam int         LSZ    = 8;
    localparam int         RD_LAT = 1;
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_R4  = 3'd2;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        req  = 1'b0;
    logic [15:0] sa   = '0;
    logic [7:0]  len  = '0;
    logic        busy;
    logic        done;
    logic [7:0]  ob;
    logic        ov;
    logic        ordy = 1'b1;
    logic [2:0]  op;
    logic [15:0] ai;
    logic [31:0] vo;

    pool_str_rd #(
        .ASZ(ASZ), .DSZ(DSZ), .LSZ(LSZ), .RD_LAT(RD_LAT),
        .OP_NOP(OP_NOP), .OP_R4(OP_R4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .sa(sa), .len(len),
        .busy(busy), .done(done), .ob(ob), .ov(ov), .ordy(ordy),
        .op(op), .ai(ai), .vo(vo)
    );

    always #5 clk = ~clk;

    // Pool model: read data appears RD_LAT cycles after the R4 cycle and is
    // garbage in every other cycle, so mistimed capture shows up in the bytes.
    logic [31:0] mem  [0:65535];
    logic [31:0] pipe [0:RD_LAT-1];
    always @(posedge clk) begin
        pipe[0] <= (op == OP_R4) ? mem[ai] : 32'hDEAD_BEEF;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign vo = pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Observations of one request
    logic [7:0]  byte_q[$];
    int          xfer_cyc_q[$];
    logic [15:0] rd_q[$];
    int          rd_cyc_q[$];
    int          first_ov_cyc, busy_first_cyc, done_cnt, done_cyc;
    int          stall_err, ov_cnt, t_req, done_busy_err;
    bit          timed_out;

    // Reference expectations
    logic [7:0]  exp_b[$];
    logic [15:0] exp_rd[$];

    function automatic logic next_ordy(input int mode, input int n);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (n % 2) == 0;
        return ($urandom % 4) != 0;
    endfunction

    // String byte i lives in word sa+i/4, lane i%4.
    task automatic build_exp(input logic [15:0] s, input logic [7:0] l);
        logic [15:0] w;
        logic [31:0] d;
        exp_b.delete();
        exp_rd.delete();
        for (int i = 0; i < int'(l); i++) begin
            w = s + 16'(i / 4);
            d = mem[w];
            exp_b.push_back(d[8*(i%4) +: 8]);
        end
        for (int k = 0; k < (int'(l) + 3) / 4; k++) exp_rd.push_back(s + 16'(k));
    endtask

    function automatic int diff_bytes();
        int n;
        n = (byte_q.size() < exp_b.size()) ? byte_q.size() : exp_b.size();
        for (int i = 0; i < n; i++) if (byte_q[i] !== exp_b[i]) return i;
        if (byte_q.size() != exp_b.size()) return n;
        return -1;
    endfunction

    function automatic int diff_reads();
        int n;
        n = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
        for (int i = 0; i < n; i++) if (rd_q[i] !== exp_rd[i]) return i;
        if (rd_q.size() != exp_rd.size()) return n;
        return -1;
    endfunction

    // Issue one request and watch the DUT until 3 cycles past done.
    task automatic run_req(input logic [15:0] s, input logic [7:0] l, input int mode, input bit pulse_busy);
        int          post;
        logic        prev_stall;
        logic [7:0]  prev_ob;
        byte_q.delete(); xfer_cyc_q.delete(); rd_q.delete(); rd_cyc_q.delete();
        first_ov_cyc = -1; busy_first_cyc = -1; done_cnt = 0; done_cyc = -1;
        stall_err = 0; ov_cnt = 0; done_busy_err = 0; timed_out = 1'b1;
        post = -1; prev_stall = 1'b0; prev_ob = '0;
        @(posedge clk); #1;
        req = 1'b1; sa = s; len = l; ordy = next_ordy(mode, 0);
        t_req = cyc;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (op == OP_R4) begin rd_q.push_back(ai); rd_cyc_q.push_back(cyc); end
            if (prev_stall && (!ov || ob !== prev_ob)) stall_err++;
            prev_stall = ov && !ordy;
            prev_ob    = ob;
            if (ov) begin ov_cnt++; if (first_ov_cyc < 0) first_ov_cyc = cyc; end
            if (ov && ordy) begin byte_q.push_back(ob); xfer_cyc_q.push_back(cyc); end
            if (busy && busy_first_cyc < 0) busy_first_cyc = cyc;
            if (done) begin
                done_cnt++; done_cyc = cyc;
                if (busy || ov) done_busy_err++;
                if (post < 0) post = 3;
            end
            if (post == 0) begin timed_out = 1'b0; break; end
            if (post > 0) post--;
            @(posedge clk); #1;
            req = 1'b0;
            if (pulse_busy && n == 4) begin req = 1'b1; sa = 16'h1234; len = 8'd3; end
            ordy = next_ordy(mode, n + 1);
        end
        ordy = 1'b1;
        req  = 1'b0;
    endtask

    task automatic load_abc();
        mem[0] = 32'h64636261; // "abcd"
        mem[1] = 32'h68676665; // "efgh"
        mem[2] = 32'h6C6B6A69; // "ijkl"
        mem[3] = 32'h706F6E6D; // "mnop"
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (op !== OP_NOP)  begin n_err++; $display("FAIL reset_op: got %0d want %0d", op, OP_NOP); end
        n_cmp++; if (ai !== 16'h0)   begin n_err++; $display("FAIL reset_ai: got %h want 0000", ai); end
        n_cmp++; if (ob !== 8'h0)    begin n_err++; $display("FAIL reset_ob: got %h want 00", ob); end
        n_cmp++; if (ov !== 1'b0)    begin n_err++; $display("FAIL reset_ov: got %b want 0", ov); end
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic_string();
        int d;
        load_abc();
        build_exp(16'h0000, 8'd16);
        run_req(16'h0000, 8'd16, 0, 1'b0);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL T1_timeout: no done within budget"); end
        d = diff_bytes();
        n_cmp++; if (d >= 0) begin n_err++; $display("FAIL T1_bytes: idx %0d got %h want %h (count %0d want %0d)", d, (d < byte_q.size()) ? byte_q[d] : 8'h0, (d < exp_b.size()) ? exp_b[d] : 8'h0, byte_q.size(), exp_b.size()); end
        d = diff_reads();
        n_cmp++; if (d >= 0) begin n_err++; $display("FAIL T1_reads: idx %0d count %0d want %0d", d, rd_q.size(), exp_rd.size()); end
        n_cmp++; if (rd_cyc_q.size() == 0 || rd_cyc_q[0] != t_req + 1) begin n_err++; $display("FAIL T1_r4_latency: got cycle %0d want %0d", (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -1, t_req + 1); end
        n_cmp++; if (busy_first_cyc != t_req + 1) begin n_err++; $display("FAIL T1_busy_rise: got %0d want %0d", busy_first_cyc, t_req + 1); end
        n_cmp++; if (first_ov_cyc != t_req + 2 + RD_LAT) begin n_err++; $display("FAIL T1_ov_latency: got %0d want %0d", first_ov_cyc, t_req + 2 + RD_LAT); end
        n_cmp++; if (xfer_cyc_q.size() < 5 || xfer_cyc_q[4] - xfer_cyc_q[3] != 2 + RD_LAT || xfer_cyc_q[1] - xfer_cyc_q[0] != 1) begin n_err++; $display("FAIL T1_word_gap: transfers %0d, gap wrong (want %0d)", xfer_cyc_q.size(), 2 + RD_LAT); end
        n_cmp++; if (xfer_cyc_q.size() == 0 || done_cyc != xfer_cyc_q[$] + 1) begin n_err++; $display("FAIL T1_done_timing: got %0d want last byte + 1", done_cyc); end
        n_cmp++; if (done_cnt != 1 || done_busy_err != 0) begin n_err++; $display("FAIL T1_done_pulse: got %0d pulses, %0d with busy/ov, want 1 and 0", done_cnt, done_busy_err); end
    endtask

    task automatic test_offset_partial();
        int d;
        build_exp(16'h0001, 8'd6);
        run_req(16'h0001, 8'd6, 0, 1'b0);
        d = diff_bytes();
        n_cmp++; if (d >= 0 || timed_out) begin n_err++; $display("FAIL T2_bytes: idx %0d count %0d want %0d timeout %0b", d, byte_q.size(), exp_b.size(), timed_out); end
        d = diff_reads();
        n_cmp++; if (d >= 0) begin n_err++; $display("FAIL T2_reads: got %0d reads want %0d (idx %0d)", rd_q.size(), exp_rd.size(), d); end
    endtask

    task automatic test_zero_len();
        run_req(16'h0002, 8'd0, 0, 1'b0);
        n_cmp++; if (done_cyc != t_req + 1) begin n_err++; $display("FAIL T3_done_cycle: got %0d want %0d", done_cyc, t_req + 1); end
        n_cmp++; if (rd_q.size() != 0) begin n_err++; $display("FAIL T3_no_read: got %0d reads want 0", rd_q.size()); end
        n_cmp++; if (ov_cnt != 0) begin n_err++; $display("FAIL T3_no_ov: got %0d ov cycles want 0", ov_cnt); end
        n_cmp++; if (busy_first_cyc != -1) begin n_err++; $display("FAIL T3_no_busy: busy seen at %0d want never", busy_first_cyc); end
    endtask

    task automatic test_backpressure();
        int d;
        load_abc();
        build_exp(16'h0000, 8'd16);
        run_req(16'h0000, 8'd16, 1, 1'b0);
        d = diff_bytes();
        n_cmp++; if (d >= 0 || timed_out) begin n_err++; $display("FAIL T4_bytes: idx %0d count %0d want %0d", d, byte_q.size(), exp_b.size()); end
        n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL T4_stall_hold: got %0d unstable stall cycles want 0", stall_err); end
    endtask

    task automatic test_wrap();
        int d;
        mem[16'hFFFF] = $urandom;
        build_exp(16'hFFFF, 8'd8);
        run_req(16'hFFFF, 8'd8, 0, 1'b0);
        d = diff_reads();
        n_cmp++; if (d >= 0) begin n_err++; $display("FAIL T5_reads: idx %0d got %h want %h", d, (d < rd_q.size()) ? rd_q[d] : 16'h0, (d < exp_rd.size()) ? exp_rd[d] : 16'h0); end
        d = diff_bytes();
        n_cmp++; if (d >= 0) begin n_err++; $display("FAIL T5_bytes: idx %0d count %0d want %0d", d, byte_q.size(), exp_b.size()); end
    endtask

    task automatic test_mid_reset();
        int d;
        int seen;
        load_abc();
        seen = 0;
        @(posedge clk); #1;
        req = 1'b1; sa = 16'h0000; len = 8'd16; ordy = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (ov) seen++;
            if (seen == 6) break;
        end
        n_cmp++; if (seen != 6) begin n_err++; $display("FAIL T6_reach_emit: got %0d ov cycles want 6", seen); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (op !== OP_NOP || ov !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL T6_async_reset: got op %0d ov %b busy %b want %0d 0 0", op, ov, busy, OP_NOP); end
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        build_exp(16'h0000, 8'd16);
        run_req(16'h0000, 8'd16, 0, 1'b0);
        d = diff_bytes();
        n_cmp++; if (d >= 0 || timed_out) begin n_err++; $display("FAIL T6_restart: idx %0d count %0d want %0d", d, byte_q.size(), exp_b.size()); end
        run_req(16'h0000, 8'd16, 0, 1'b1);
        d = diff_bytes();
        n_cmp++; if (d >= 0 || timed_out) begin n_err++; $display("FAIL T6_req_busy_bytes: idx %0d count %0d want %0d", d, byte_q.size(), exp_b.size()); end
        d = diff_reads();
        n_cmp++; if (d >= 0 || done_cnt != 1) begin n_err++; $display("FAIL T6_req_busy_reads: got %0d reads %0d dones want %0d and 1", rd_q.size(), done_cnt, exp_rd.size()); end
    endtask

    task automatic test_random();
        int          d;
        logic [15:0] s;
        logic [7:0]  l;
        for (int it = 0; it < 8; it++) begin
            s = (it % 3 == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
            l = 8'($urandom_range(0, 40));
            build_exp(s, l);
            run_req(s, l, 2, 1'b0);
            d = diff_bytes();
            n_cmp++; if (d >= 0 || timed_out) begin n_err++; $display("FAIL rand_bytes[%0d]: sa %h len %0d idx %0d count %0d want %0d", it, s, l, d, byte_q.size(), exp_b.size()); end
            d = diff_reads();
            n_cmp++; if (d >= 0) begin n_err++; $display("FAIL rand_reads[%0d]: sa %h len %0d got %0d reads want %0d", it, s, l, rd_q.size(), exp_rd.size()); end
            n_cmp++; if (stall_err != 0 || done_cnt != 1) begin n_err++; $display("FAIL rand_flow[%0d]: stall errors %0d dones %0d want 0 and 1", it, stall_err, done_cnt); end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        test_reset();
        test_basic_string();
        test_offset_partial();
        test_zero_len();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
